// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial N-bit two's-complement subtractor.
// One full-adder cell plus a carry flip-flop computes minuend + ~subtrahend + 1.
// It processes one bit per clock, LSB first, and uses a start/busy/done handshake.
// Optional macro SERIAL_SUB_ADD_EN adds an op_add input. With op_add=1 the block
// computes minuend + subtrahend instead.
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   start      - operation request, accepted when busy=0
//   minuend    - operand A (N bits), sampled on the accepting edge
//   subtrahend - operand B (N bits), sampled on the accepting edge
//   op_add     - (SERIAL_SUB_ADD_EN only) 1 = add, 0 = subtract
//   busy       - operation in progress
//   done       - one-cycle result-valid pulse
//   diff       - A - B modulo 2^N (held until the next completion)
//   borrow_out - A < B unsigned (raw carry-out in add mode)
//   overflow   - signed overflow (carry into MSB xor carry out of MSB)
module serial_subtractor #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] minuend,
  input  logic [N-1:0] subtrahend,
`ifdef SERIAL_SUB_ADD_EN
  input  logic         op_add,
`endif
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         borrow_out,
  output logic         overflow
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic           load;
  logic           step;
  logic           last;

  logic [N-1:0]   sha;
  logic [N-1:0]   shb;
  logic [N-1:0]   shr;
  logic [CW-1:0]  cnt;
  logic           carry;
`ifdef SERIAL_SUB_ADD_EN
  logic           add_mode;
`endif

  logic           sum_bit;
  logic           carry_out;
  logic [N-1:0]   shr_next;

  // Full-adder cell on the current LSBs.
  assign sum_bit   = sha[0] ^ shb[0] ^ carry;
  assign carry_out = (sha[0] & shb[0]) | (sha[0] & carry) | (shb[0] & carry);
  // The sum bit enters at the MSB. Shifting the concatenation also covers N == 1.
  assign shr_next  = N'({sum_bit, shr} >> 1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = RUN;
          load       = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CW'(N - 1)) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand shifters, carry, bit counter and held result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sha        <= '0;
      shb        <= '0;
      shr        <= '0;
      cnt        <= '0;
      carry      <= 1'b0;
`ifdef SERIAL_SUB_ADD_EN
      add_mode   <= 1'b0;
`endif
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      busy <= (state_next == RUN);
      done <= (state_next == DONE);
      if (load) begin
        sha   <= minuend;
        shr   <= '0;
        cnt   <= '0;
`ifdef SERIAL_SUB_ADD_EN
        shb      <= op_add ? subtrahend : ~subtrahend;
        carry    <= ~op_add;
        add_mode <= op_add;
`else
        shb   <= ~subtrahend;
        carry <= 1'b1;
`endif
      end else if (step) begin
        sha   <= sha >> 1;
        shb   <= shb >> 1;
        shr   <= shr_next;
        carry <= carry_out;
        if (last) begin
          // On the MSB step, carry holds the carry into the MSB.
          diff     <= shr_next;
          overflow <= carry ^ carry_out;
`ifdef SERIAL_SUB_ADD_EN
          borrow_out <= add_mode ? carry_out : ~carry_out;
`else
          borrow_out <= ~carry_out;
`endif
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor (N=4).
// An arithmetic reference model predicts every output on every cycle.
// Hand-computed results pin the model on selected operations.
module tb_serial_subtractor;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] minuend;
  logic [N-1:0] subtrahend;
`ifdef SERIAL_SUB_ADD_EN
  logic         op_add;
`endif
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         borrow_out;
  logic         overflow;

  serial_subtractor #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .minuend    (minuend),
    .subtrahend (subtrahend),
`ifdef SERIAL_SUB_ADD_EN
    .op_add     (op_add),
`endif
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an operation completes N edges after it is accepted.
  bit         m_busy, m_done, m_borrow, m_ovf;
  bit [N-1:0] m_diff;
  bit [N-1:0] p_diff;
  bit         p_borrow, p_ovf;
  int         remaining;

  always @(posedge clk) begin
    int ua, ub, sa, sb, r, sr;
    bit is_add;
    if (rst) begin
      m_busy = 0; m_done = 0; m_diff = '0; m_borrow = 0; m_ovf = 0;
      remaining = 0;
    end else begin
      m_done = 0;
      if (remaining > 0) begin
        remaining--;
        if (remaining == 0) begin
          m_busy = 0; m_done = 1;
          m_diff = p_diff; m_borrow = p_borrow; m_ovf = p_ovf;
        end
      end else if (start) begin
`ifdef SERIAL_SUB_ADD_EN
        is_add = op_add;
`else
        is_add = 1'b0;
`endif
        ua = int'(minuend);
        ub = int'(subtrahend);
        sa = (ua >= 2 ** (N - 1)) ? ua - 2 ** N : ua;
        sb = (ub >= 2 ** (N - 1)) ? ub - 2 ** N : ub;
        if (is_add) begin
          r = ua + ub; sr = sa + sb;
          p_borrow = (r >= 2 ** N);
        end else begin
          r = ua - ub; sr = sa - sb;
          p_borrow = (ua < ub);
        end
        p_diff = N'(r);
        p_ovf  = (sr < -(2 ** (N - 1))) || (sr > 2 ** (N - 1) - 1);
        remaining = N;
        m_busy = 1;
      end
    end
  end

  // Hand-computed results, indexed by completion number (written by the driver only).
  logic [N+1:0] lit_exp   [16];
  bit           lit_valid [16];

  int n_cmp = 0;
  int n_bad = 0;
  int comp_idx = 0;

  // Compare process: every output on every cycle, plus hand-computed results at completions.
  always @(negedge clk) begin
    logic [N+3:0] exp_v, act_v;
    exp_v = {m_busy, m_done, m_diff, m_borrow, m_ovf};
    act_v = {busy, done, diff, borrow_out, overflow};
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL cycle_check t=%0t busy,done,diff,borrow,ovf actual=%b required=%b",
               $time, act_v, exp_v);
    end
    if (m_done) begin
      if (comp_idx < 16 && lit_valid[comp_idx]) begin
        n_cmp++;
        if ({diff, borrow_out, overflow} !== lit_exp[comp_idx]) begin
          n_bad++;
          $display("FAIL literal_dut op#%0d diff,borrow,ovf actual=%b required=%b",
                   comp_idx, {diff, borrow_out, overflow}, lit_exp[comp_idx]);
        end
        n_cmp++;
        if ({m_diff, m_borrow, m_ovf} !== lit_exp[comp_idx]) begin
          n_bad++;
          $display("FAIL literal_model op#%0d diff,borrow,ovf actual=%b required=%b",
                   comp_idx, {m_diff, m_borrow, m_ovf}, lit_exp[comp_idx]);
        end
      end
      comp_idx++;
    end
  end

  // Bounded wait for done. A missing pulse shows up in the per-cycle check.
  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int i = 0; i < 4 * N; i++) begin
      if (!seen) begin
        @(negedge clk);
        seen = (done === 1'b1);
      end
    end
  endtask

  task automatic do_op(input int idx, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N+1:0] expv);
    lit_exp[idx]   = expv;
    lit_valid[idx] = 1;
    minuend = a; subtrahend = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      lit_valid[i] = 0;
      lit_exp[i]   = '0;
    end
    rst = 1'b1; start = 1'b0; minuend = '0; subtrahend = '0;
`ifdef SERIAL_SUB_ADD_EN
    op_add = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases: {diff, borrow_out, overflow}
    do_op(0, 4'b0111, 4'b0101, {4'b0010, 1'b0, 1'b0});
    do_op(1, 4'b0101, 4'b0111, {4'b1110, 1'b1, 1'b0});
    do_op(2, 4'b1000, 4'b0001, {4'b0111, 1'b0, 1'b1});
    do_op(3, 4'b0000, 4'b0000, {4'b0000, 1'b0, 1'b0});

    // start held during RUN is ignored. It is accepted again in the DONE cycle.
    lit_exp[4] = {4'b0010, 1'b0, 1'b0}; lit_valid[4] = 1;
    lit_exp[5] = {4'b1110, 1'b0, 1'b0}; lit_valid[5] = 1;
    minuend = 4'b0111; subtrahend = 4'b0101; start = 1'b1;
    @(negedge clk);
    minuend = 4'b1111; subtrahend = 4'b0001;
    wait_done();
    @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);

    // Reset on the second RUN edge aborts the operation without a done pulse.
    minuend = 4'b0111; subtrahend = 4'b0101; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    do_op(6, 4'b0011, 4'b0001, {4'b0010, 1'b0, 1'b0});

`ifdef SERIAL_SUB_ADD_EN
    op_add = 1'b1;
    do_op(7, 4'b0111, 4'b0101, {4'b1100, 1'b0, 1'b1});
    op_add = 1'b0;
`endif

    // Random traffic: starts at any time, occasional resets.
    for (int c = 0; c < 800; c++) begin
      start      = ($urandom_range(0, 2) == 0);
      minuend    = N'($urandom);
      subtrahend = N'($urandom);
`ifdef SERIAL_SUB_ADD_EN
      op_add     = 1'($urandom);
`endif
      rst        = ($urandom_range(0, 99) == 0);
      @(negedge clk);
    end
    rst = 1'b0; start = 1'b0;
    repeat (10) @(negedge clk);
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
